// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for a serial stream produced by a WIDTH-bit Fibonacci
//   LFSR. It seeds its history from the received bits and looks for LOCK_CNT
//   consecutive correct predictions before it declares lock. Once locked, it
//   runs its own copy of the generator and flags every received bit that
//   differs from the prediction. LOSS_CNT consecutive misses drop it back to
//   searching.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_bit carries a stream bit this cycle
//   in_bit     in   1      received stream bit
//   clr_count  in   1      synchronous clear of err_count (wins over increment)
//   locked     out  1      synchronised, checking active
//   err_pulse  out  1      one-cycle strobe for a mismatched bit while locked
//   err_count  out  CNT_W  saturating mismatch count while locked
module lfsr_checker #(
  parameter int               WIDTH    = 26,
  parameter logic [WIDTH-1:0] TAPS     = 26'h2000023,
  parameter int               LOCK_CNT = 32,
  parameter int               LOSS_CNT = 8,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   hist_reg;
  logic [FILL_W-1:0]  fill_reg;
  logic [MATCH_W-1:0] match_cnt_reg;
  logic [MISS_W-1:0]  miss_cnt_reg;
  logic               locked_reg;
  logic               err_pulse_reg;
  logic [CNT_W-1:0]   err_count_reg;

  // hist_reg[i-1] holds b[n-i]; the prediction is the XOR of the tapped bits.
  logic [WIDTH-1:0] tapped;
  logic             pred;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tapped[gi] = hist_reg[gi] & TAPS[gi];
    end
  endgenerate

  assign pred = ^tapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SEARCH;
      hist_reg      <= '0;
      fill_reg      <= '0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      err_pulse_reg <= 1'b0;

      if (in_valid) begin
        case (state_reg)
          SEARCH: begin
            // Received bits seed the history while searching.
            hist_reg <= {hist_reg[WIDTH-2:0], in_bit};
            if (fill_reg < FILL_W'(WIDTH)) begin
              fill_reg <= fill_reg + FILL_W'(1);
            end else if ((pred == in_bit) && (hist_reg != '0)) begin
              // An all-zero history predicts zeros forever, so it never counts.
              if (match_cnt_reg == MATCH_W'(LOCK_CNT - 1)) begin
                state_reg     <= LOCKED;
                locked_reg    <= 1'b1;
                match_cnt_reg <= '0;
                miss_cnt_reg  <= '0;
              end else begin
                match_cnt_reg <= match_cnt_reg + MATCH_W'(1);
              end
            end else begin
              match_cnt_reg <= '0;
            end
          end

          LOCKED: begin
            // Free-running local generator: a corrupted bit never enters the history.
            hist_reg <= {hist_reg[WIDTH-2:0], pred};
            if (in_bit != pred) begin
              err_pulse_reg <= 1'b1;
              if (err_count_reg != '1) begin
                err_count_reg <= err_count_reg + CNT_W'(1);
              end
              if (miss_cnt_reg == MISS_W'(LOSS_CNT - 1)) begin
                state_reg     <= SEARCH;
                locked_reg    <= 1'b0;
                fill_reg      <= '0;
                match_cnt_reg <= '0;
                miss_cnt_reg  <= '0;
              end else begin
                miss_cnt_reg <= miss_cnt_reg + MISS_W'(1);
              end
            end else begin
              miss_cnt_reg <= '0;
            end
          end

          default: state_reg <= SEARCH;
        endcase
      end

      // Placed last so a clear beats an increment in the same cycle.
      if (clr_count) begin
        err_count_reg <= '0;
      end
    end
  end

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

  localparam int          W    = 26;
  localparam logic [25:0] TAPS = 26'h2000023;
  localparam int          LOCK = 32;
  localparam int          LOSS = 8;
  localparam int          CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr_count = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  lfsr_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_count (clr_count),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transmitter: true sequence as a bit list, newest at the back.
  bit gen_q[$];
  // Reference checker: its own bit list plus plain integer counters.
  bit m_hist[$];
  bit m_locked;
  bit m_pulse;
  int m_fill, m_match, m_miss, m_count;

  // Counters of observed events within a test.
  int pulses_seen;
  int locked_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Recurrence: b[n] = XOR of b[n-i] for every tap bit i-1 set.
  function automatic bit predict(input bit q[$]);
    bit p = 1'b0;
    for (int i = 1; i <= W; i++)
      if (TAPS[i-1]) p ^= q[q.size() - i];
    return p;
  endfunction

  function automatic bit all_zero(input bit q[$]);
    for (int i = 0; i < q.size(); i++)
      if (q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic gen_seed(input logic [25:0] s);
    gen_q.delete();
    for (int i = W; i >= 1; i--) gen_q.push_back(s[i-1]);
  endtask

  task automatic gen_next(output bit b);
    b = predict(gen_q);
    gen_q.push_back(b);
    void'(gen_q.pop_front());
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
    m_locked = 0; m_pulse = 0;
    m_fill = 0; m_match = 0; m_miss = 0; m_count = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    bit p;
    m_pulse = 0;
    if (v) begin
      p = predict(m_hist);
      if (!m_locked) begin
        if (m_fill < W) m_fill++;
        else if (p == b && !all_zero(m_hist)) m_match++;
        else m_match = 0;
        if (m_match == LOCK) begin m_locked = 1; m_match = 0; m_miss = 0; end
        m_hist.push_back(b);
      end else begin
        m_hist.push_back(p);
        if (b != p) begin
          m_pulse = 1;
          if (m_count < CMAX) m_count++;
          m_miss++;
          if (m_miss == LOSS) begin
            m_locked = 0; m_fill = 0; m_match = 0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
      void'(m_hist.pop_front());
    end
    if (clr) m_count = 0;
  endtask

  // One clock: drive, let the edge happen, then compare against the model.
  task automatic step(input bit v, input bit b, input bit clr);
    in_valid = v; in_bit = b; clr_count = clr;
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    check_eq("locked", locked, m_locked);
    check_eq("err_pulse", err_pulse, m_pulse);
    check_eq("err_count", err_count, m_count);
    if (err_pulse) pulses_seen++;
    if (locked) locked_seen++;
  endtask

  task automatic do_reset();
    in_valid = 0; in_bit = 0; clr_count = 0;
    #2 rst_n = 0;
    #1;
    check_eq("rst_locked", locked, 0);
    check_eq("rst_pulse", err_pulse, 0);
    check_eq("rst_count", err_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    pulses_seen = 0; locked_seen = 0;
  endtask

  task automatic rand_seed();
    logic [25:0] s;
    s = 26'($urandom());
    if (s == 0) s = 26'h1;
    gen_seed(s);
  endtask

  initial begin
    bit b;
    int injected;

    // 1: clean stream from the reference seed locks after exactly 58 bits.
    do_reset();
    gen_seed(26'h2F1112D);
    for (int k = 1; k <= 100; k++) begin
      gen_next(b);
      step(1, b, 0);
      if (k == 57) check_eq("t1_not_locked_57", locked, 0);
      if (k == 58) check_eq("t1_locked_58", locked, 1);
    end
    check_eq("t1_count", err_count, 0);
    check_eq("t1_no_pulse", pulses_seen, 0);
    $display("test1 clean lock done");

    // 2: single inverted bit at position 80.
    do_reset();
    gen_seed(26'h2F1112D);
    for (int k = 1; k <= 150; k++) begin
      gen_next(b);
      step(1, b ^ (k == 80), 0);
      if (k == 80) check_eq("t2_pulse_80", err_pulse, 1);
    end
    check_eq("t2_count", err_count, 1);
    check_eq("t2_pulses", pulses_seen, 1);
    check_eq("t2_locked", locked, 1);
    $display("test2 single error done");

    // 3: eight consecutive errors drop lock, clean stream relocks after 58.
    step(0, 0, 1);
    check_eq("t3_cleared", err_count, 0);
    for (int k = 1; k <= 8; k++) begin
      gen_next(b);
      step(1, ~b, 0);
      if (k == 7) check_eq("t3_still_locked", locked, 1);
    end
    check_eq("t3_lost", locked, 0);
    check_eq("t3_count8", err_count, 8);
    for (int k = 1; k <= 70; k++) begin
      gen_next(b);
      step(1, b, 0);
      if (k == 57) check_eq("t3_relock_57", locked, 0);
      if (k == 58) check_eq("t3_relock_58", locked, 1);
    end
    check_eq("t3_count_held", err_count, 8);
    $display("test3 loss and relock done");

    // 4: all-zero stream never locks.
    do_reset();
    for (int k = 1; k <= 200; k++) step(1, 0, 0);
    check_eq("t4_never_locked", locked_seen, 0);
    check_eq("t4_count", err_count, 0);
    $display("test4 zero stream done");

    // 5: valid every other cycle; 58th valid bit lands on cycle 116.
    do_reset();
    rand_seed();
    for (int c = 1; c <= 116; c++) begin
      if (c % 2 == 0) begin gen_next(b); step(1, b, 0); end
      else step(0, 0, 0);
      if (c == 115) check_eq("t5_not_locked_115", locked, 0);
    end
    check_eq("t5_locked_116", locked, 1);
    check_eq("t5_no_pulse", pulses_seen, 0);
    gen_next(b); step(1, ~b, 0);
    check_eq("t5_count1", err_count, 1);
    gen_next(b); step(1, ~b, 1);
    check_eq("t5_clr_wins", err_count, 0);
    check_eq("t5_clr_pulse", err_pulse, 1);
    $display("test5 gapped stream and clear done");

    // Randomized traffic: gaps, sporadic errors, bursts, clears, noise.
    do_reset();
    rand_seed();
    for (int k = 0; k < 4000; k++) begin
      bit v, e, c;
      v = ($urandom_range(3) != 0);
      c = ($urandom_range(63) == 0);
      e = ($urandom_range(19) == 0) || (k >= 2000 && k < 2012);
      if (k >= 3000 && k < 3150) begin
        step(v, 1'($urandom()), c);
      end else if (v) begin
        gen_next(b);
        step(1, b ^ e, c);
      end else begin
        step(0, 1'($urandom()), c);
      end
    end
    $display("random phase done checks=%0d", checks);

    // 6: saturate the counter while staying locked (7 errors, 1 good bit).
    do_reset();
    rand_seed();
    for (int k = 1; k <= 58; k++) begin gen_next(b); step(1, b, 0); end
    check_eq("t6_locked", locked, 1);
    injected = 0;
    while (injected < CMAX + 5) begin
      for (int j = 0; j < 7 && injected < CMAX + 5; j++) begin
        gen_next(b); step(1, ~b, 0); injected++;
      end
      gen_next(b); step(1, b, 0);
    end
    check_eq("t6_saturated", err_count, 16'hFFFF);
    check_eq("t6_still_locked", locked, 1);
    #2 rst_n = 0;
    #1;
    check_eq("t6_rst_locked", locked, 0);
    check_eq("t6_rst_count", err_count, 0);
    check_eq("t6_rst_pulse", err_pulse, 0);
    $display("test6 saturation and async reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
